// File: rtl/sme_match_reader.sv
// Buffers the SME rule-ID match stream for the core: stored IDs go to a rule FIFO,
// and each packet boundary pushes a {overflow, count} descriptor to a second FIFO.
module sme_match_reader #(
  parameter int RULE_DEPTH = 64,
  parameter int DESC_DEPTH = 16,
  parameter int MAX_RULES  = 32,
  parameter int CNT_W      = $clog2(MAX_RULES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      match_rules_ID,
  input  logic             match_last,
  input  logic             match_valid,
  output logic             match_release,
  output logic [CNT_W-1:0] desc_count,
  output logic             desc_overflow,
  output logic             desc_valid,
  input  logic             desc_pop,
  output logic [31:0]      rule_data,
  output logic             rule_valid,
  input  logic             rule_pop,
  output logic [15:0]      drop_cnt
);

  localparam int RA = $clog2(RULE_DEPTH);
  localparam int DA = $clog2(DESC_DEPTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RULES);

  logic [31:0]    rule_mem [RULE_DEPTH];
  logic [CNT_W:0] desc_mem [DESC_DEPTH];

  logic [RA:0] rule_wr_ptr_reg, rule_wr_ptr_next, rule_rd_ptr_reg, rule_rd_ptr_next;
  logic [DA:0] desc_wr_ptr_reg, desc_wr_ptr_next, desc_rd_ptr_reg, desc_rd_ptr_next;
  logic        rule_full_reg, rule_full_next, desc_full_reg, desc_full_next;
  logic [CNT_W-1:0] cur_cnt_reg, cur_cnt_next, cnt_stored;
  logic        cur_ovf_reg, cur_ovf_next;
  logic [15:0] drop_cnt_reg, drop_cnt_next;
  logic        accept, store, drop, desc_push, rule_do_pop, desc_do_pop;
  logic [CNT_W:0] desc_word, desc_head;

  // Depends only on registered full flags, so no combinational path from match_valid.
  assign match_release = !rst && !rule_full_reg && !desc_full_reg;

  assign rule_valid = (rule_wr_ptr_reg != rule_rd_ptr_reg);
  assign desc_valid = (desc_wr_ptr_reg != desc_rd_ptr_reg);
  assign desc_head  = desc_mem[desc_rd_ptr_reg[DA-1:0]];

  // Heads are masked so outputs read 0 while empty, including straight out of reset.
  assign rule_data     = rule_valid ? rule_mem[rule_rd_ptr_reg[RA-1:0]] : '0;
  assign desc_count    = desc_valid ? desc_head[CNT_W-1:0] : '0;
  assign desc_overflow = desc_valid ? desc_head[CNT_W] : 1'b0;
  assign drop_cnt      = drop_cnt_reg;

  always_comb begin
    accept      = match_valid && match_release;
    store       = accept && (match_rules_ID != 32'd0) && (cur_cnt_reg < MAX_C);
    drop        = accept && (match_rules_ID != 32'd0) && !(cur_cnt_reg < MAX_C);
    desc_push   = accept && match_last;
    rule_do_pop = rule_pop && rule_valid;
    desc_do_pop = desc_pop && desc_valid;

    cnt_stored = cur_cnt_reg + {{(CNT_W-1){1'b0}}, store};
    desc_word  = {cur_ovf_reg | drop, cnt_stored};

    rule_wr_ptr_next = rule_wr_ptr_reg + {{RA{1'b0}}, store};
    rule_rd_ptr_next = rule_rd_ptr_reg + {{RA{1'b0}}, rule_do_pop};
    desc_wr_ptr_next = desc_wr_ptr_reg + {{DA{1'b0}}, desc_push};
    desc_rd_ptr_next = desc_rd_ptr_reg + {{DA{1'b0}}, desc_do_pop};

    rule_full_next = (rule_wr_ptr_next[RA] != rule_rd_ptr_next[RA]) &&
                     (rule_wr_ptr_next[RA-1:0] == rule_rd_ptr_next[RA-1:0]);
    desc_full_next = (desc_wr_ptr_next[DA] != desc_rd_ptr_next[DA]) &&
                     (desc_wr_ptr_next[DA-1:0] == desc_rd_ptr_next[DA-1:0]);

    cur_cnt_next = desc_push ? '0 : cnt_stored;
    cur_ovf_next = desc_push ? 1'b0 : (cur_ovf_reg | drop);

    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_next = drop_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rule_wr_ptr_reg <= '0;
      rule_rd_ptr_reg <= '0;
      desc_wr_ptr_reg <= '0;
      desc_rd_ptr_reg <= '0;
      rule_full_reg   <= 1'b0;
      desc_full_reg   <= 1'b0;
      cur_cnt_reg     <= '0;
      cur_ovf_reg     <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      rule_wr_ptr_reg <= rule_wr_ptr_next;
      rule_rd_ptr_reg <= rule_rd_ptr_next;
      desc_wr_ptr_reg <= desc_wr_ptr_next;
      desc_rd_ptr_reg <= desc_rd_ptr_next;
      rule_full_reg   <= rule_full_next;
      desc_full_reg   <= desc_full_next;
      cur_cnt_reg     <= cur_cnt_next;
      cur_ovf_reg     <= cur_ovf_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  // Storage arrays carry no reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (store) begin
      rule_mem[rule_wr_ptr_reg[RA-1:0]] <= match_rules_ID;
    end
    if (desc_push) begin
      desc_mem[desc_wr_ptr_reg[DA-1:0]] <= desc_word;
    end
  end

endmodule

// File: tb/tb_sme_match_reader.sv
// Directed bench for sme_match_reader: hand-computed descriptors, rule order,
// truncation, full-FIFO back-pressure and mid-packet reset.
module tb_sme_match_reader;

  localparam int CNT_W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] match_rules_ID = '0;
  logic        match_last = 1'b0;
  logic        match_valid = 1'b0;
  logic        match_release;
  logic [CNT_W-1:0] desc_count;
  logic        desc_overflow;
  logic        desc_valid;
  logic        desc_pop = 1'b0;
  logic [31:0] rule_data;
  logic        rule_valid;
  logic        rule_pop = 1'b0;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sme_match_reader #(
    .RULE_DEPTH(64), .DESC_DEPTH(16), .MAX_RULES(32), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .match_rules_ID(match_rules_ID), .match_last(match_last),
    .match_valid(match_valid), .match_release(match_release),
    .desc_count(desc_count), .desc_overflow(desc_overflow),
    .desc_valid(desc_valid), .desc_pop(desc_pop),
    .rule_data(rule_data), .rule_valid(rule_valid), .rule_pop(rule_pop),
    .drop_cnt(drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [31:0] id, input logic last);
    int waited = 0;
    match_rules_ID = id;
    match_last     = last;
    match_valid    = 1'b1;
    while (!match_release && waited < 200) begin
      tick();
      waited++;
    end
    check_eq("send_release", 32'(match_release), 32'd1);
    tick();
    match_valid = 1'b0;
    match_last  = 1'b0;
  endtask

  task automatic pop_rule(input logic [31:0] exp);
    check_eq("rule_valid", 32'(rule_valid), 32'd1);
    check_eq("rule_data", rule_data, exp);
    $display("rule pop: 0x%0h (expect 0x%0h)", rule_data, exp);
    rule_pop = 1'b1;
    tick();
    rule_pop = 1'b0;
  endtask

  task automatic pop_desc(input logic ovf, input int cnt);
    check_eq("desc_valid", 32'(desc_valid), 32'd1);
    check_eq("desc_overflow", 32'(desc_overflow), 32'(ovf));
    check_eq("desc_count", 32'(desc_count), 32'(cnt));
    $display("desc pop: ovf=%0d count=%0d (expect %0d/%0d)", desc_overflow, desc_count, ovf, cnt);
    desc_pop = 1'b1;
    tick();
    desc_pop = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_rule_valid"}, 32'(rule_valid), 32'd0);
    check_eq({tag, "_desc_valid"}, 32'(desc_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(); tick();
    check_eq("rst_release", 32'(match_release), 32'd0);
    check_eq("rst_desc_valid", 32'(desc_valid), 32'd0);
    check_eq("rst_rule_valid", 32'(rule_valid), 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_eq("rst_rule_data", rule_data, 32'd0);
    check_eq("rst_desc_count", 32'(desc_count), 32'd0);
    check_eq("rst_desc_ovf", 32'(desc_overflow), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_release", 32'(match_release), 32'd1);

    // Three-rule packet
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b1);
    pop_desc(1'b0, 3);
    pop_rule(32'h11);
    pop_rule(32'h22);
    pop_rule(32'h33);
    check_empty("pkt3");

    // Zero-match packet
    send(32'h0, 1'b1);
    check_eq("zero_rule_valid", 32'(rule_valid), 32'd0);
    pop_desc(1'b0, 0);
    check_empty("zero");

    // Truncation: 40 IDs, 32 kept, 8 dropped
    for (int i = 0; i < 40; i++) send(32'h100 + 32'(i), (i == 39));
    check_eq("trunc_drop_cnt", 32'(drop_cnt), 32'd8);
    pop_desc(1'b1, 32);
    for (int i = 0; i < 32; i++) pop_rule(32'h100 + 32'(i));
    check_empty("trunc");

    // Rule FIFO fills mid-packet: three 30-rule packets, no pops
    for (int i = 0; i < 64; i++) begin
      send(32'h200 + 32'(i), ((i % 30) == 29));
      if (i == 62) check_eq("rule_not_full_63", 32'(match_release), 32'd1);
    end
    check_eq("rule_full_stall", 32'(match_release), 32'd0);
    pop_desc(1'b0, 30);
    for (int i = 0; i < 30; i++) pop_rule(32'h200 + 32'(i));
    check_eq("rule_resume", 32'(match_release), 32'd1);
    for (int i = 64; i < 90; i++) send(32'h200 + 32'(i), ((i % 30) == 29));
    pop_desc(1'b0, 30);
    for (int i = 30; i < 60; i++) pop_rule(32'h200 + 32'(i));
    pop_desc(1'b0, 30);
    for (int i = 60; i < 90; i++) pop_rule(32'h200 + 32'(i));
    check_empty("full3");
    check_eq("drop_cnt_held", 32'(drop_cnt), 32'd8);

    // Descriptor FIFO full: 16 packets fill it, 17th stalls until one pop
    for (int k = 0; k < 16; k++) send(32'h300 + 32'(k), 1'b1);
    check_eq("desc_full_stall", 32'(match_release), 32'd0);
    match_rules_ID = 32'h310;
    match_last     = 1'b1;
    match_valid    = 1'b1;
    desc_pop       = 1'b1;
    check_eq("desc_head_cnt", 32'(desc_count), 32'd1);
    tick();
    desc_pop = 1'b0;
    check_eq("desc_resume", 32'(match_release), 32'd1);
    tick();
    match_valid = 1'b0;
    match_last  = 1'b0;
    check_eq("desc_refull", 32'(match_release), 32'd0);
    for (int k = 0; k < 16; k++) pop_desc(1'b0, 1);
    check_eq("desc_drained", 32'(desc_valid), 32'd0);
    for (int k = 0; k < 17; k++) pop_rule(32'h300 + 32'(k));
    check_empty("desc17");

    // Reset in the middle of a packet with buffered entries present
    send(32'h3FF, 1'b1);
    send(32'h400, 1'b0);
    match_rules_ID = 32'h401;
    match_valid    = 1'b1;
    rst            = 1'b1;
    tick();
    check_empty("midrst");
    check_eq("midrst_release", 32'(match_release), 32'd0);
    check_eq("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst         = 1'b0;
    match_valid = 1'b0;
    #1;
    check_eq("midrst_release_after", 32'(match_release), 32'd1);
    send(32'h500, 1'b1);
    pop_desc(1'b0, 1);
    pop_rule(32'h500);
    check_empty("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
